// File: rtl/bus_arbiter_pkg.sv
// Shared serial-bus definitions: default node count, frame layout and the
// arbiter FSM encoding. The frame datapath imports the same field offsets.
package bus_arbiter_pkg;

  localparam int ID_W = 4;  // grant_id width, supports up to 16 nodes

  localparam int BUS_N_NODES = 16;

  // Frame layout, bit 0 first on the wire: ADDR 0..3, DATA 4..67, CRC 68..71
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 4;
  localparam int DATA_LSB = ADDR_LSB + ADDR_W;
  localparam int DATA_W   = 64;
  localparam int CRC_LSB  = DATA_LSB + DATA_W;
  localparam int CRC_W    = 4;

  localparam int BUS_FRAME_LEN = CRC_LSB + CRC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req        : per-node request vector
//   last_owner : index of the previous winner; search starts one above it
//   winner     : one-hot winning node
//   win_id     : binary index of the winner
//   valid      : at least one request present
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N = BUS_N_NODES
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_owner,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] win_id,
  output logic            valid
);

  logic [ID_W-1:0] idx;

  // Walk N positions starting at last_owner+1, wrapping N-1 -> 0; the first
  // set request wins, so last_owner itself is checked last.
  always_comb begin
    winner = '0;
    win_id = '0;
    valid  = 1'b0;
    idx    = last_owner;
    for (int k = 0; k < N; k++) begin
      idx = (idx == ID_W'(N - 1)) ? '0 : idx + ID_W'(1);
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        win_id      = idx;
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection and frame sequencing for a shared
// serial bus. One frame of FRAME_LEN bits per grant, then GAP_CYCLES idle
// cycles, then one IDLE cycle in which req is sampled.
//   clock, reset : rising-edge clock, async active-high reset
//   req          : level-sensitive per-node transmit request
//   grant        : one-hot owner, only during SEND
//   grant_id     : binary owner index for the frame mux
//   bit_idx      : frame bit on the bus, 0 outside SEND
//   frame_start  : high during bit 0
//   frame_end    : high during bit FRAME_LEN-1
//   done         : pulse to the owner during its frame_end cycle
//   bus_busy     : high in SEND and GAP
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_NODES    = BUS_N_NODES,
  parameter int FRAME_LEN  = BUS_FRAME_LEN,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_NODES-1:0] req,
  output logic [N_NODES-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [6:0]         bit_idx,
  output logic               frame_start,
  output logic               frame_end,
  output logic [N_NODES-1:0] done,
  output logic               bus_busy
);

  localparam logic [6:0] LAST_BIT = 7'(FRAME_LEN - 1);
  // Wraps to 127 when FRAME_LEN==1; never reached then, the entry edge
  // raises frame_end instead.
  localparam logic [6:0] PRE_LAST = 7'(FRAME_LEN - 2);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  bus_state_e         state;
  logic [ID_W-1:0]    last_owner;
  logic [3:0]         gap_cnt;

  logic [N_NODES-1:0] pick_oh;
  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;

  rr_picker #(.N(N_NODES)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_oh),
    .win_id     (pick_id),
    .valid      (pick_vld)
  );

  // All outputs are registered here. frame_end/done are raised one edge early
  // so they sit exactly on the last bit cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_owner  <= ID_W'(N_NODES - 1);
      grant       <= '0;
      grant_id    <= '0;
      bit_idx     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      done        <= '0;
      bus_busy    <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      done        <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state       <= ST_SEND;
            grant       <= pick_oh;
            grant_id    <= pick_id;
            last_owner  <= pick_id;
            bit_idx     <= '0;
            frame_start <= 1'b1;
            bus_busy    <= 1'b1;
            if (FRAME_LEN == 1) begin
              frame_end <= 1'b1;
              done      <= pick_oh;
            end
          end
        end
        ST_SEND: begin
          // req is not looked at here: the frame always runs to completion
          if (bit_idx == LAST_BIT) begin
            state    <= ST_GAP;
            grant    <= '0;
            grant_id <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
          end else begin
            bit_idx <= bit_idx + 7'd1;
            if (bit_idx == PRE_LAST) begin
              frame_end <= 1'b1;
              done      <= grant;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            bus_busy <= 1'b0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int N   = 16;
  localparam int FL  = 72;
  localparam int GAP = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  grant, done;
  logic [3:0]    grant_id;
  logic [6:0]    bit_idx;
  logic          frame_start, frame_end, bus_busy;

  int n_chk  = 0;
  int n_fail = 0;

  bus_arbiter #(.N_NODES(N), .FRAME_LEN(FL), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .bit_idx     (bit_idx),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .done        (done),
    .bus_busy    (bus_busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int k = 0;
    while (!(bus_busy === 1'b0 && grant === '0) && k < 400) begin
      tick();
      k++;
    end
    timed_out = (k >= 400);
  endtask

  task automatic test_reset();
    req = 16'hFFFF;
    #1;
    n_chk++;
    if ({grant, done, grant_id, bit_idx, frame_start, frame_end, bus_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%h done=%h id=%0d bit=%0d fs=%b fe=%b busy=%b expected all 0",
               grant, done, grant_id, bit_idx, frame_start, frame_end, bus_busy);
    end
    repeat (3) tick();
    n_chk++;
    if ({grant, done, grant_id, bit_idx, frame_start, frame_end, bus_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: grant=%h bit=%0d busy=%b expected all 0", grant, bit_idx, bus_busy);
    end
  endtask

  task automatic test_single();
    bit to;
    reset = 1'b1;
    req   = 16'h0001;
    tick();
    reset = 1'b0;
    tick();
    n_chk++;
    if (grant !== 16'h0001 || grant_id !== 4'd0 || bit_idx !== 7'd0 || frame_start !== 1'b1 || bus_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first: grant=%h id=%0d bit=%0d fs=%b busy=%b expected 0001/0/0/1/1",
               grant, grant_id, bit_idx, frame_start, bus_busy);
    end
    for (int k = 1; k < FL; k++) begin
      tick();
      n_chk++;
      if (bit_idx !== 7'(k) || grant !== 16'h0001 || frame_start !== 1'b0 ||
          frame_end !== (k == FL - 1) || done !== ((k == FL - 1) ? 16'h0001 : 16'h0000)) begin
        n_fail++;
        $display("FAIL single_bit%0d: bit=%0d grant=%h fs=%b fe=%b done=%h", k, bit_idx, grant, frame_start, frame_end, done);
      end
    end
    tick();
    n_chk++;
    if (grant !== '0 || bit_idx !== 7'd0 || bus_busy !== 1'b1 || done !== '0 || frame_end !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: grant=%h bit=%0d busy=%b done=%h expected 0/0/1/0", grant, bit_idx, bus_busy, done);
    end
    tick();
    n_chk++;
    if (grant !== '0 || bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: grant=%h busy=%b expected 0/0", grant, bus_busy);
    end
    tick();
    n_chk++;
    if (grant !== 16'h0001 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_regrant: grant=%h fs=%b expected 0001/1 at period 74", grant, frame_start);
    end
    req = '0;
    wait_idle(to);
    n_chk++;
    if (to) begin n_fail++; $display("FAIL single_drain: busy=%b expected 0", bus_busy); end
  endtask

  // Collects frame starts and checks owner order and 74-cycle spacing.
  task automatic run_order(input string name, input logic [N-1:0] r, input int exp_ids[6]);
    bit to;
    do_reset();
    req = r;
    for (int f = 0; f < 6; f++) begin
      int n = 0;
      do begin tick(); n++; end while (frame_start !== 1'b1 && n < 300);
      n_chk++;
      if (frame_start !== 1'b1 || grant !== (16'(1) << exp_ids[f]) || grant_id !== 4'(exp_ids[f])) begin
        n_fail++;
        $display("FAIL %s_frame%0d: grant=%h id=%0d expected node %0d", name, f, grant, grant_id, exp_ids[f]);
      end
      if (f > 0) begin
        n_chk++;
        if (n != FL + GAP + 1) begin
          n_fail++;
          $display("FAIL %s_period%0d: got %0d cycles expected %0d", name, f, n, FL + GAP + 1);
        end
      end
    end
    req = '0;
    wait_idle(to);
    n_chk++;
    if (to) begin n_fail++; $display("FAIL %s_drain: busy=%b expected 0", name, bus_busy); end
  endtask

  task automatic test_round_robin();
    int ids[6] = '{0, 1, 2, 0, 1, 2};
    run_order("rr", 16'h0007, ids);
  endtask

  task automatic test_wrap();
    int ids[6] = '{0, 15, 0, 15, 0, 15};
    run_order("wrap", 16'h8001, ids);
  endtask

  task automatic test_drop();
    do_reset();
    req = 16'h0010;
    tick();
    n_chk++;
    if (grant !== 16'h0010 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_start: grant=%h fs=%b expected 0010/1", grant, frame_start);
    end
    repeat (10) tick();
    n_chk++;
    if (bit_idx !== 7'd10) begin n_fail++; $display("FAIL drop_bit10: bit=%0d expected 10", bit_idx); end
    req = '0;
    repeat (61) tick();
    n_chk++;
    if (bit_idx !== 7'd71 || frame_end !== 1'b1 || done !== 16'h0010 || grant !== 16'h0010) begin
      n_fail++;
      $display("FAIL drop_end: bit=%0d fe=%b done=%h grant=%h expected 71/1/0010/0010", bit_idx, frame_end, done, grant);
    end
    tick();
    n_chk++;
    if (bus_busy !== 1'b1 || grant !== '0) begin
      n_fail++;
      $display("FAIL drop_gap: busy=%b grant=%h expected 1/0", bus_busy, grant);
    end
    repeat (2) tick();
    n_chk++;
    if (bus_busy !== 1'b0 || grant !== '0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%b grant=%h fs=%b expected 0/0/0", bus_busy, grant, frame_start);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    req = 16'h0004;
    tick();
    repeat (40) tick();
    n_chk++;
    if (bit_idx !== 7'd40 || grant !== 16'h0004) begin
      n_fail++;
      $display("FAIL rmid_bit40: bit=%0d grant=%h expected 40/0004", bit_idx, grant);
    end
    req = 16'h0002;
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({grant, done, grant_id, bit_idx, frame_start, frame_end, bus_busy} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: grant=%h bit=%0d busy=%b done=%h expected all 0", grant, bit_idx, bus_busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (done !== '0 || frame_end !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_nodone%0d: done=%h fe=%b expected 0/0", k, done, frame_end);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    n_chk++;
    if (grant !== 16'h0002 || grant_id !== 4'd1 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_regrant: grant=%h id=%0d fs=%b expected 0002/1/1", grant, grant_id, frame_start);
    end
    req = '0;
    wait_idle(to);
    n_chk++;
    if (to) begin n_fail++; $display("FAIL rmid_drain: busy=%b expected 0", bus_busy); end
  endtask

  // Reference model: a frame is a span of time starting at its grant. Offsets
  // 0..FL-1 are data bits, FL..FL+GAP-1 gap, then one idle cycle samples req.
  task automatic test_random();
    int in_frame = 0, off = 0, owner = 0, last = N - 1;
    int start_c = -1, wait_cnt[N], max_wait = 0;
    logic [N-1:0] req_prev = '0, nr, eg, ed;
    logic [6:0] eb;
    logic efs, efe, ebusy;
    bit found;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      eg = '0; ed = '0; eb = '0; efs = 0; efe = 0; ebusy = 0;
      if (in_frame != 0) begin
        ebusy = 1;
        if (off < FL) begin
          eg  = 16'(1) << owner;
          eb  = 7'(off);
          efs = (off == 0);
          efe = (off == FL - 1);
          if (efe) ed = eg;
        end
      end
      n_chk++;
      if (grant !== eg || bit_idx !== eb || frame_start !== efs || frame_end !== efe || done !== ed || bus_busy !== ebusy) begin
        n_fail++;
        $display("FAIL rand_c%0d: grant=%h/%h bit=%0d/%0d fs=%b/%b fe=%b/%b done=%h/%h busy=%b/%b (got/expected)",
                 c, grant, eg, bit_idx, eb, frame_start, efs, frame_end, efe, done, ed, bus_busy, ebusy);
      end
      if (in_frame != 0 && off < FL) begin
        n_chk++;
        if (grant_id !== 4'(owner)) begin
          n_fail++;
          $display("FAIL rand_id_c%0d: id=%0d expected %0d", c, grant_id, owner);
        end
      end
      n_chk++;
      if (!$onehot0(grant) || bit_idx >= 7'(FL)) begin
        n_fail++;
        $display("FAIL rand_shape_c%0d: grant=%h bit=%0d expected onehot0 and <%0d", c, grant, bit_idx, FL);
      end
      if (frame_start === 1'b1) begin
        start_c = c;
        for (int i = 0; i < N; i++) begin
          if (req_prev[i] && grant[i] !== 1'b1) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        n_chk++;
        if (max_wait > 15) begin
          n_fail++;
          $display("FAIL rand_starve_c%0d: waited %0d frames expected <=15", c, max_wait);
        end
      end
      if (frame_end === 1'b1 && start_c >= 0) begin
        n_chk++;
        if (c - start_c != FL - 1) begin
          n_fail++;
          $display("FAIL rand_span_c%0d: got %0d cycles expected %0d", c, c - start_c, FL - 1);
        end
      end
      case ($urandom_range(3))
        0:       nr = '0;
        1:       nr = 16'(1) << $urandom_range(N - 1);
        2:       nr = 16'($urandom);
        default: nr = req;
      endcase
      req      = nr;
      req_prev = nr;
      if (in_frame != 0) begin
        off++;
        if (off == FL + GAP) in_frame = 0;
      end else if (nr != '0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && nr[4'((last + k) % N)]) begin
            found = 1;
            owner = (last + k) % N;
          end
        end
        last     = owner;
        in_frame = 1;
        off      = 0;
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_NODES, default 16, number of sender nodes sharing the serial bus.
REQ-002 Parameter FRAME_LEN, default 72, bits per frame (4 addr + 64 data + 4 CRC).
REQ-003 Parameter GAP_CYCLES, default 1, idle bus cycles after each frame; legal range 1..15.
REQ-004 clock  input  1  single clock, rising edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_NODES  per-node transmit request (node i = bit i), level-sensitive.
REQ-007 grant  output  N_NODES  one-hot bus ownership, registered.
REQ-008 grant_id  output  4  binary index of the granted node, drives the datapath frame mux.
REQ-009 bit_idx  output  7  index of the frame bit currently on the bus, 0..FRAME_LEN-1.
REQ-010 frame_start  output  1  pulse high during bit_idx 0 of each frame.
REQ-011 frame_end  output  1  pulse high during bit_idx FRAME_LEN-1 of each frame.
REQ-012 done  output  N_NODES  one-cycle pulse to the owner during its frame_end cycle.
REQ-013 bus_busy  output  1  high while in SEND or GAP.

Function
REQ-014 FSM states SHALL be IDLE, SEND and GAP, with IDLE as the reset state.
REQ-015 IDLE with req==0 SHALL stay in IDLE with grant, done, frame_start and frame_end all 0.
REQ-016 IDLE with req!=0 SHALL, at the next edge, enter SEND with grant/grant_id set to the winner, bit_idx=0 and frame_start=1, for one-cycle latency.
REQ-017 The winner SHALL be the first set req bit searching upward from (last_owner+1) mod N_NODES, wrapping 15 to 0 (round-robin).
REQ-018 last_owner SHALL update to the winner on entry to SEND; a lone requester SHALL be re-granted immediately.
REQ-019 In SEND, bit_idx SHALL increment by 1 per cycle, and grant/grant_id SHALL stay constant for exactly FRAME_LEN cycles.
REQ-020 When bit_idx==FRAME_LEN-1, frame_end and done[owner] SHALL be 1, and the next edge SHALL enter GAP with grant=0 and bit_idx=0.
REQ-021 GAP SHALL last GAP_CYCLES cycles, counted by an internal counter, then return to IDLE.
REQ-022 Back-to-back frames SHALL have period FRAME_LEN+GAP_CYCLES+1 cycles.
REQ-023 req changes during SEND or GAP SHALL be ignored, including deassertion by the owner; a frame always completes.
REQ-024 req SHALL be sampled only in IDLE, and simultaneous requests SHALL be resolved solely by REQ-017.
REQ-025 grant SHALL never have more than one bit set, and SHALL be 0 outside SEND.
REQ-026 bit_idx SHALL be held at 0 outside SEND.

Reset
REQ-027 reset SHALL force state=IDLE and last_owner=N_NODES-1, so node 0 has first priority.
REQ-028 reset SHALL force grant=0, grant_id=0, bit_idx=0, frame_start=0, frame_end=0, done=0, bus_busy=0 and the gap counter=0, immediately and without a clock edge.
REQ-029 reset asserted mid-frame SHALL abort the frame with no done pulse; after release, arbitration SHALL restart from IDLE.

Structure
REQ-030 N_NODES, FRAME_LEN, the field offsets (ADDR 0..3, DATA 4..67, CRC 68..71) and the FSM state encoding SHALL live in the shared bus package, which the datapath also uses.
REQ-031 The round-robin priority picker SHALL be a sub-module rr_picker (inputs req and last_owner; outputs one-hot winner, binary index and valid), purely combinational.

Verification
REQ-032 req=0x0001 held at release of reset -> grant=0x0001 one edge later, frame_end 71 cycles after frame_start, done[0] pulse, re-grant of node 0 at a 74-cycle period.
REQ-033 req=0x0007 constant -> grant order 0,1,2,0,1,2, each frame 72 cycles, 1 gap cycle between frames.
REQ-034 last_owner=15 with req=0x8001 -> node 0 wins (wrap); the next frame goes to node 15.
REQ-035 Owner drops req at bit_idx 10 -> frame still ends at bit_idx 71 with its done pulse, then IDLE.
REQ-036 reset pulsed at bit_idx 40 -> all outputs 0 immediately, no done; after release with req=0x0002, node 1 is granted.
REQ-037 Random req for 10k cycles -> assertions: grant one-hot or zero, bit_idx<72, frame_start/frame_end spaced 71 cycles apart, no node starved beyond 15 frames.
